hs_fifo_afifo: RTL and testbench

Single-clock, packet-aware first-word-fall-through FIFO with valid/ready handshakes on both the write and read sides. Write beats are staged speculatively and become visible to the reader only when a beat with `wlast` commits the packet. A beat flagged `wdrop` discards the whole in-progress packet. The block sits between a packet producer and a consumer in the same clock domain and reports fill levels and almost-full/almost-empty flags for flow control.

---
 rtl/hs_fifo_afifo.sv | 100 ++++++++++
 tb/tb_hs_fifo_afifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_afifo.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_afifo
// Description : Single-clock packet-aware FWFT FIFO; write beats become
//               readable only once a wlast beat commits the packet.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo_afifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wdrop,
  output logic                  walmost_full,
  output logic [LW-1:0]         wlevel,
  input  logic                  rready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  ralmost_empty,
  output logic [LW-1:0]         rlevel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] C_DEPTH  = PW'(FIFO_DEPTH);
  localparam logic [LW-1:0] C_AFULL  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] C_AEMPTY = LW'(AEMPTY_LVL);

  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_cm_ptr;
  logic [PW-1:0]       r_rd_ptr;

  logic [PW-1:0]       w_wr_diff;
  logic [PW-1:0]       w_cm_diff;
  logic [PW-1:0]       w_wr_ptr_inc;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [DATA_WIDTH:0] w_head;

  // Extra pointer bit distinguishes full (diff == depth) from empty (diff == 0)
  assign w_wr_diff    = r_wr_ptr - r_rd_ptr;
  assign w_cm_diff    = r_cm_ptr - r_rd_ptr;
  assign w_wr_ptr_inc = r_wr_ptr + PW'(1);

  assign wready   = !rst && (w_wr_diff != C_DEPTH);
  assign rvalid   = !rst && (r_cm_ptr != r_rd_ptr);
  assign w_wr_acc = wvalid && wready;
  assign w_rd_acc = rvalid && rready;

  assign wlevel        = rst ? '0 : LW'(w_wr_diff);
  assign rlevel        = rst ? '0 : LW'(w_cm_diff);
  assign walmost_full  = (wlevel >= C_AFULL);
  assign ralmost_empty = (rlevel <= C_AEMPTY);

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign rdata  = w_head[DATA_WIDTH-1:0];
  assign rlast  = w_head[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        // A drop rewinds the speculative pointer, discarding the open packet
        if (wdrop) begin
          r_wr_ptr <= r_cm_ptr;
        end else begin
          r_wr_ptr <= w_wr_ptr_inc;
          if (wlast) begin
            r_cm_ptr <= w_wr_ptr_inc;
          end
        end
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !wdrop) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {wlast, wdata};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_fifo_afifo.sv
`default_nettype none
// Testbench for hs_fifo_afifo: driver pushes committed beats into a
// scoreboard queue, a monitor pops and compares on every read handshake.
`timescale 1ns/1ps
module tb_hs_fifo_afifo;

  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          wdrop;
  logic          walmost_full;
  logic [LW-1:0] wlevel;
  logic          rready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          ralmost_empty;
  logic [LW-1:0] rlevel;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_mode = 0;  // 0 manual, 1 always ready, 2 random

  logic [DW:0] exp_q[$];
  logic [DW:0] pend_q[$];

  hs_fifo_afifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .wdrop(wdrop), .walmost_full(walmost_full), .wlevel(wlevel),
    .rready(rready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reader handshake generator
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rd_mode == 1) rready = 1'b1;
      else if (rd_mode == 2) rready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on every read handshake, check flags against levels
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_read", {rlast, rdata}, 64'hDEAD);
          end else begin
            chk("read_beat", {rlast, rdata}, exp_q.pop_front());
          end
        end
        chk("ralmost_empty", ralmost_empty, rlevel <= 4);
        chk("walmost_full", walmost_full, wlevel >= 12);
      end
    end
  end

  task automatic write_beat(input logic [DW-1:0] d, input logic last, input logic drop);
    bit acc = 0;
    wvalid = 1'b1; wdata = d; wlast = last; wdrop = drop;
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; wdrop = 1'b0;
    if (!acc) begin
      chk("write_timeout", 0, 1);
    end else if (drop) begin
      pend_q.delete();
    end else begin
      pend_q.push_back({last, d});
      if (last) begin
        while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    int i = 0;
    rd_mode = 1;
    while ((rlevel != 0 || exp_q.size() != 0) && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_done", exp_q.size(), 0);
    rd_mode = 0; rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int len, drop_at;
    logic [DW-1:0] seq;
    rst = 1'b1; wvalid = 0; wdata = 0; wlast = 0; wdrop = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_walmost_full", walmost_full, 0);
    chk("rst_ralmost_empty", ralmost_empty, 1);
    rst = 1'b0;
    #1;
    chk("post_rst_wready", wready, 1);
    @(posedge clk); #1;

    // 3-beat packet, visible only after commit
    write_beat(32'hA0, 0, 0);
    chk("a_rvalid_uncommitted", rvalid, 0);
    chk("a_wlevel1", wlevel, 1);
    write_beat(32'hA1, 0, 0);
    chk("a_rlevel_uncommitted", rlevel, 0);
    write_beat(32'hA2, 1, 0);
    chk("a_rvalid_committed", rvalid, 1);
    chk("a_rlevel3", rlevel, 3);
    chk("a_wlevel3", wlevel, 3);
    drain();

    // Dropped packet followed by a single-beat packet
    write_beat(32'hB0, 0, 0);
    write_beat(32'hB1, 0, 0);
    chk("b_wlevel2", wlevel, 2);
    chk("b_rvalid", rvalid, 0);
    write_beat(32'hBF, 0, 1);
    chk("b_wlevel_after_drop", wlevel, 0);
    chk("b_rvalid_after_drop", rvalid, 0);
    write_beat(32'hC0, 1, 0);
    chk("c_rlevel1", rlevel, 1);
    drain();

    // Fill with 16 single-beat packets
    for (int i = 0; i < 16; i++) begin
      write_beat(32'hD0 + i, 1, 0);
      if (i == 10) chk("full_afull_at11", walmost_full, 0);
      if (i == 11) chk("full_afull_at12", walmost_full, 1);
    end
    chk("full_wready", wready, 0);
    chk("full_wlevel", wlevel, 16);
    chk("full_rlevel", rlevel, 16);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("full_wready_after_read", wready, 1);
    chk("full_wlevel_after_read", wlevel, 15);
    drain();

    // Reader stall: head must hold steady
    write_beat(32'hE0, 0, 0);
    write_beat(32'hE1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdata", rdata, 32'hE0);
      chk("stall_rlast", rlast, 0);
      chk("stall_rvalid", rvalid, 1);
      @(posedge clk); #1;
    end
    drain();

    // Random-length stream with random gaps, reads and drops
    rd_mode = 2;
    seq = 32'h1000;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 8);
      drop_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : 99;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 9) < 3) begin
          @(posedge clk); #1;
        end
        if (b == drop_at) begin
          write_beat(32'hFFFF_0000, 0, 1);
          break;
        end
        write_beat(seq, b == len - 1, 0);
        seq++;
      end
    end
    drain();

    // Reset mid-packet with committed data pending
    for (int i = 0; i < 5; i++) write_beat(32'h50 + i, i == 4, 0);
    write_beat(32'h60, 0, 0);
    write_beat(32'h61, 0, 0);
    chk("mid_rlevel5", rlevel, 5);
    chk("mid_wlevel7", wlevel, 7);
    rst = 1'b1;
    exp_q.delete();
    pend_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_wlevel", wlevel, 0);
    chk("mid_rst_rlevel", rlevel, 0);
    chk("mid_rst_wready", wready, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_wready", wready, 1);
    @(posedge clk); #1;
    chk("mid_post_rvalid", rvalid, 0);
    chk("mid_post_rlevel", rlevel, 0);
    write_beat(32'hF0, 1, 0);
    chk("mid_post_rlevel1", rlevel, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
